order_content_ram: RTL and testbench
====================================

# order_content_ram

Parametrised, single-clock, true dual-port successor to the fixed 4096x793 order-content store in `router_output_port_lookup`.
- Port A serves the lookup pipeline; port B serves the order-update/control path.
- Adds automatic post-reset clearing of every entry, a selectable output register stage, read-valid flags, and defined same-address behaviour between the two ports.

## Interface
Parameters:
- `DATA_WIDTH`, 793, width of one order-content entry.
- `ADDR_WIDTH`, 12, address width; depth is 2**ADDR_WIDTH.
- `OUT_REG`, 1, 0 or 1: extra output register stage on both ports.
- `INIT_VALUE`, 0, value written into every entry during the init sweep.

Ports:
- `clk`  in  1  single clock for everything.
- `reset`  in  1  synchronous, active-high.
- `init_done`  out  1  high once the init sweep has finished; ports accept commands only while it is high.
- `en_a`  in  1  port A command strobe.
- `we_a`  in  1  port A write (qualified by `en_a`).
- `addr_a`  in  ADDR_WIDTH  port A address.
- `din_a`  in  DATA_WIDTH  port A write data.
- `dout_a`  out  DATA_WIDTH  port A read data.
- `dout_valid_a`  out  1  `dout_a` valid this cycle.
- `en_b`, `we_b`, `addr_b`, `din_b`, `dout_b`, `dout_valid_b`: same as port A, for port B.
- `collision`  out  1  one-cycle pulse when both ports write the same address in the same cycle.

## Operation
State machine: `ST_INIT` and `ST_READY`.
- **Reset:** `reset` high forces `ST_INIT`, clears the sweep counter, and clears all outputs. This applies at any time, including mid-sweep or mid-traffic; the sweep restarts at address 0.
- **`ST_INIT`:**
  - Writes `INIT_VALUE` to address `cnt`, one entry per cycle, for `cnt` = 0 .. 2**ADDR_WIDTH-1.
  - On the last address, moves to `ST_READY`.
  - `en_a`/`en_b` are ignored; no writes are taken and no valids are produced.
- **`ST_READY`:** terminal state until the next reset. `init_done` = 1.
- **Per-port command** (`en` = 1):
  - `we` = 1: writes `din` to `addr`. Write-first: `dout` returns `din`, and `dout_valid` pulses.
  - `we` = 0: reads `addr`; `dout_valid` pulses.
  - `en` = 0: `dout` holds its previous value; `dout_valid` = 0.
- **Cross-port, same address, same cycle:**
  - A writes, B reads: B returns A's new data (bypass, write-first across ports).
  - B writes, A reads: A returns B's new data.
  - Both write: A's data is stored and returned on both ports; B's write is dropped; `collision` pulses with the same latency as `dout_valid`.
- **Widths:** no arithmetic on data. The sweep counter is ADDR_WIDTH+1 bits so that termination is detected without wrap-around.

## Timing
- **Reset values:** `dout_a`/`dout_b` = 0, `dout_valid_a`/`dout_valid_b` = 0, `collision` = 0, `init_done` = 0.
- **Init duration:**
  - `reset` is high in cycle 0 and low from cycle 1.
  - Sweep writes occur in cycles 1 .. 2**ADDR_WIDTH.
  - `init_done` = 1 from cycle 2**ADDR_WIDTH + 1.
  - The first command is accepted in that same cycle.
- **Read/write latency:** 1 + OUT_REG cycles from the `en` cycle to `dout`/`dout_valid`. Default is 2.
- **Throughput:** one command per port per cycle, with no back-pressure.
- **Write visibility:** a write in cycle n is visible to a read of the same address from either port issued in cycle n+1. A same-cycle read is covered by the cross-port rule above.
- **Output register:** with OUT_REG = 1, the register stage is also cleared by `reset`. Data in flight when `reset` asserts is discarded.

## Structure
- Shared package/header `order_content_pkg`:
  - state encodings `ST_INIT`, `ST_READY`;
  - default `DATA_WIDTH`/`ADDR_WIDTH` constants, reused by the lookup top level.
- Storage array carries the `ram_style = "block"` attribute. Each port has its own write process so that true dual-port BRAM is inferred; B's write enable is gated by the collision compare.
- One sub-module: `order_content_out_stage`, the per-port optional output register with a generate on OUT_REG. It is instantiated twice.

## Test plan
Benches use ADDR_WIDTH=4, DATA_WIDTH=16 unless stated.
- **Init sweep:** first fill all 16 entries with 0xFFFF via a pre-run, then reset with INIT_VALUE=0x1234 → `init_done` rises exactly at cycle 17, and reads of addresses 0..15 all return 0x1234.
- **Latency:** with OUT_REG=0 and OUT_REG=1, port A writes 0xBEEF @5 → `dout_a`=0xBEEF with `dout_valid_a` at latency 1 / 2; port B reading @5 one cycle later returns 0xBEEF.
- **Cross-port read bypass:** A writes 0x00AA @3 while B reads @3 in the same cycle → `dout_b`=0x00AA, and `collision`=0.
- **Write collision:** A writes 0x1111 @7 and B writes 0x2222 @7 → `collision` pulses once; both `dout`=0x1111; a later read @7 returns 0x1111.
- **Reset mid-traffic:**
  - Assert `reset` during back-to-back reads → both valids drop the next cycle and `init_done`=0.
  - Commands presented during the new sweep are ignored.
  - After the sweep, previously written @5 now reads INIT_VALUE.
- **Full-size smoke:** defaults (793x4096), random two-port traffic checked against a reference model for 20k cycles → no mismatches.

Source files
------------

// File: rtl/order_content_pkg.sv
// Shared definitions for the order-content store.
// Holds the default entry geometry (reused by the lookup top level) and the
// state encoding of the post-reset init sweep.
package order_content_pkg;

    localparam int OC_DATA_WIDTH = 793;
    localparam int OC_ADDR_WIDTH = 12;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } oc_state_t;

endpackage

// File: rtl/order_content_out_stage.sv
// Optional output register for one port of the order-content store.
// OUT_REG = 0: straight wire. OUT_REG = 1: one register stage that only
// loads data when valid_in is high, so the port output holds between reads.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   data_in, valid_in     first-stage read data and its valid flag
//   data_out, valid_out   port output data and valid
module order_content_out_stage
    import order_content_pkg::*;
#(
    parameter int WIDTH   = OC_DATA_WIDTH,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    generate
        if (OUT_REG != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out  <= '0;
                    valid_out <= 1'b0;
                end else begin
                    valid_out <= valid_in;
                    if (valid_in)
                        data_out <= data_in;
                end
            end
        end else begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign data_out  = data_in;
            assign valid_out = valid_in;
        end
    endgenerate

endmodule

// File: rtl/order_content_ram.sv
// True dual-port order-content store with post-reset init sweep.
// Port A serves the lookup pipeline, port B the order-update/control path.
// After reset every entry is written with INIT_VALUE (one per cycle); the
// ports accept commands only once init_done is high.
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   init_done                     sweep finished, ports live
//   en_x, we_x, addr_x, din_x     port command (x = a, b)
//   dout_x, dout_valid_x          read data / valid, latency 1 + OUT_REG
//   collision                     both ports wrote the same address (A wins)
module order_content_ram
    import order_content_pkg::*;
#(
    parameter int                    DATA_WIDTH = OC_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = OC_ADDR_WIDTH,
    parameter int                    OUT_REG    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  dout_valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  dout_valid_b,
    output logic                  collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    oc_state_t             state, state_next;
    logic [ADDR_WIDTH:0]   cnt, cnt_next;
    logic                  ready;

    // ---------------- init sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter carries one extra bit: its carry out of the address range
    // marks the last sweep write without the address wrapping back to 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_INIT: begin
                cnt_next = cnt + 1'b1;
                if (cnt_next[ADDR_WIDTH])
                    state_next = ST_READY;
            end
            ST_READY: ;
            default: state_next = ST_INIT;
        endcase
    end

    assign ready     = (state == ST_READY);
    assign init_done = ready;

    // ---------------- command decode ----------------
    logic cmd_a, cmd_b, wr_a, wr_b, same_addr, coll, wr_b_eff;

    assign cmd_a     = ready & en_a;
    assign cmd_b     = ready & en_b;
    assign wr_a      = cmd_a & we_a;
    assign wr_b      = cmd_b & we_b;
    assign same_addr = (addr_a == addr_b);
    assign coll      = wr_a & wr_b & same_addr;
    assign wr_b_eff  = wr_b & ~coll;   // A owns the entry on a write clash

    // ---------------- storage ----------------
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port A write: also carries the init sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!ready)
                mem[cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
            else if (wr_a)
                mem[addr_a] <= din_a;
        end
    end

    // Port B write.
    always_ff @(posedge clk) begin
        if (!reset && wr_b_eff)
            mem[addr_b] <= din_b;
    end

    // ---------------- first read stage ----------------
    logic [DATA_WIDTH-1:0] q_a, q_b;
    logic                  v_a, v_b, coll_q;

    // Write-first within a port, and a same-cycle write from the other port
    // is forwarded so both ports see the value that ends up stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a <= '0;
            v_a <= 1'b0;
        end else begin
            v_a <= cmd_a;
            if (cmd_a) begin
                if (we_a)
                    q_a <= din_a;
                else if (wr_b && same_addr)
                    q_a <= din_b;
                else
                    q_a <= mem[addr_a];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_b <= '0;
            v_b <= 1'b0;
        end else begin
            v_b <= cmd_b;
            if (cmd_b) begin
                if (wr_a && same_addr)
                    q_b <= din_a;
                else if (we_b)
                    q_b <= din_b;
                else
                    q_b <= mem[addr_b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            coll_q <= 1'b0;
        else
            coll_q <= coll;
    end

    // ---------------- optional output stage ----------------
    order_content_out_stage #(.WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_out_a (
        .clk       (clk),
        .reset     (reset),
        .data_in   (q_a),
        .valid_in  (v_a),
        .data_out  (dout_a),
        .valid_out (dout_valid_a)
    );

    order_content_out_stage #(.WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_out_b (
        .clk       (clk),
        .reset     (reset),
        .data_in   (q_b),
        .valid_in  (v_b),
        .data_out  (dout_b),
        .valid_out (dout_valid_b)
    );

    // Collision is a pulse, so it is delayed rather than held.
    generate
        if (OUT_REG != 0) begin : g_coll_reg
            always_ff @(posedge clk) begin
                if (reset)
                    collision <= 1'b0;
                else
                    collision <= coll_q;
            end
        end else begin : g_coll_pass
            assign collision = coll_q;
        end
    endgenerate

endmodule

// File: tb/tb_order_content_ram.sv
// Bench for order_content_ram: two instances (OUT_REG 0 and 1) share one
// stimulus stream. A history-based reference model records what each command
// must return; outputs are compared every cycle, plus literal spot checks.
module tb_order_content_ram;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NE = 4096;
    localparam logic [DW-1:0] INITV = 16'h1234;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;

    logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic dva0, dvb0, dva1, dvb1, col0, col1, idn0, idn1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    order_content_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .INIT_VALUE(INITV)) u0 (
        .clk(clk), .reset(reset), .init_done(idn0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a0), .dout_valid_a(dva0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b0), .dout_valid_b(dvb0), .collision(col0)
    );

    order_content_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .INIT_VALUE(INITV)) u1 (
        .clk(clk), .reset(reset), .init_done(idn1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a1), .dout_valid_a(dva1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b1), .dout_valid_b(dvb1), .collision(col1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per clock edge: was reset sampled, is the store ready afterwards, and
    // what each port's command returns (valid/data) plus collision.
    int e = -1;
    bit rst_h [NE];
    bit rdy_h [NE];
    bit cc_h  [NE];
    bit cv_h  [2][NE];
    logic [DW-1:0] cd_h [2][NE];
    logic [DW-1:0] mm [16];

    initial begin : model
        int sweep;
        bit ready, wa, wb, same;
        sweep = 16;
        ready = 0;
        forever begin
            @(posedge clk);
            e++;
            if (e >= NE) begin
                $display("FAIL model_history_overflow e=%0d", e);
                $fatal(1, "history overflow");
            end
            rst_h[e] = reset;
            cv_h[0][e] = 0;
            cv_h[1][e] = 0;
            cc_h[e] = 0;
            if (reset) begin
                sweep = 16;
                ready = 0;
            end else if (!ready) begin
                mm[16 - sweep] = INITV;
                sweep--;
                if (sweep == 0) ready = 1;
            end else begin
                wa = en_a && we_a;
                wb = en_b && we_b;
                same = (addr_a == addr_b);
                if (en_a) begin
                    cv_h[0][e] = 1;
                    cd_h[0][e] = we_a ? din_a : ((wb && same) ? din_b : mm[addr_a]);
                end
                if (en_b) begin
                    cv_h[1][e] = 1;
                    cd_h[1][e] = (wa && same) ? din_a : (we_b ? din_b : mm[addr_b]);
                end
                cc_h[e] = wa && wb && same;
                if (wb && !(wa && same)) mm[addr_b] = din_b;
                if (wa) mm[addr_a] = din_a;
            end
            rdy_h[e] = ready;
        end
    end

    // Output after edge k with latency L reflects the command of edge k-L+1,
    // unless a reset edge came later; data holds the most recent valid result
    // since the last reset.
    function automatic void expect_port(input int p, input int L, input int k,
                                        output bit v, output bit c, output logic [DW-1:0] d);
        int j;
        bit blk;
        j = k - L + 1;
        blk = 0;
        v = 0;
        c = 0;
        d = '0;
        for (int m = j + 1; m <= k; m++) if (rst_h[m]) blk = 1;
        if (blk) return;
        v = cv_h[p][j];
        c = cc_h[j];
        for (int m = j; m >= 0; m--) begin
            if (rst_h[m]) break;
            if (cv_h[p][m]) begin
                d = cd_h[p][m];
                break;
            end
        end
    endfunction

    task automatic check_dut(input int id, input int L, input int k,
                             input logic [DW-1:0] da, input logic va,
                             input logic [DW-1:0] db, input logic vb,
                             input logic col, input logic idn);
        bit v, c;
        logic [DW-1:0] d;
        expect_port(0, L, k, v, c, d);
        chk($sformatf("u%0d.valid_a", id), va, v);
        chk($sformatf("u%0d.dout_a", id), da, d);
        chk($sformatf("u%0d.collision", id), col, c);
        expect_port(1, L, k, v, c, d);
        chk($sformatf("u%0d.valid_b", id), vb, v);
        chk($sformatf("u%0d.dout_b", id), db, d);
        chk($sformatf("u%0d.init_done", id), idn, rdy_h[k]);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (e >= 1) begin
                check_dut(0, 1, e, dout_a0, dva0, dout_b0, dvb0, col0, idn0);
                check_dut(1, 2, e, dout_a1, dva1, dout_b1, dvb1, col1, idn1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit ea, input bit wa, input int aa, input logic [DW-1:0] da,
                         input bit eb, input bit wb, input int ab, input logic [DW-1:0] db);
        @(negedge clk);
        en_a = ea; we_a = wa; addr_a = aa[AW-1:0]; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab[AW-1:0]; din_b = db;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset sampled at edge 0, sweep on edges 1..16, ready after edge 16
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("init_low_c16_u0", idn0, 0);
        chk("init_low_c16_u1", idn1, 0);
        at_edge();
        chk("init_rise_c17_u0", idn0, 1);
        chk("init_rise_c17_u1", idn1, 1);

        // pre-fill with 0xFFFF, then reset and confirm the sweep overwrote all
        for (int i = 0; i < 16; i++) drive(1, 1, i, 16'hFFFF, 0, 0, 0, '0);
        idle();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i, '0, 1, 0, 15 - i, '0);
            at_edge();
            chk($sformatf("sweep_rd_a%0d", i), dout_a0, 16'h1234);
        end
        idle();

        // latency: A writes 0xBEEF @5, B reads it next cycle
        drive(1, 1, 5, 16'hBEEF, 0, 0, 0, '0);
        at_edge();
        chk("lat1_dout_a", dout_a0, 16'hBEEF);
        chk("lat1_valid_a", dva0, 1);
        chk("lat2_valid_a_early", dva1, 0);
        drive(0, 0, 0, '0, 1, 0, 5, '0);
        at_edge();
        chk("lat2_dout_a", dout_a1, 16'hBEEF);
        chk("lat2_valid_a", dva1, 1);
        chk("b_rd_lat1", dout_b0, 16'hBEEF);
        chk("hold_valid_a_low", dva0, 0);
        idle();
        at_edge();
        chk("b_rd_lat2", dout_b1, 16'hBEEF);
        chk("hold_dout_a", dout_a0, 16'hBEEF);

        // cross-port bypass: A writes 0x00AA @3, B reads @3 same cycle
        drive(1, 1, 3, 16'h00AA, 1, 0, 3, '0);
        at_edge();
        chk("bypass_dout_b", dout_b0, 16'h00AA);
        chk("bypass_no_coll", col0, 0);
        idle();
        at_edge();
        chk("bypass_dout_b_l2", dout_b1, 16'h00AA);

        // write collision @7: A wins
        drive(1, 1, 7, 16'h1111, 1, 1, 7, 16'h2222);
        at_edge();
        chk("coll_pulse_l1", col0, 1);
        chk("coll_dout_a", dout_a0, 16'h1111);
        chk("coll_dout_b", dout_b0, 16'h1111);
        chk("coll_l2_early", col1, 0);
        idle();
        at_edge();
        chk("coll_pulse_end", col0, 0);
        chk("coll_pulse_l2", col1, 1);
        chk("coll_dout_b_l2", dout_b1, 16'h1111);
        idle();
        at_edge();
        chk("coll_l2_end", col1, 0);
        drive(0, 0, 0, '0, 1, 0, 7, '0);
        at_edge();
        chk("coll_readback", dout_b0, 16'h1111);

        // reset mid-traffic
        for (int i = 0; i < 3; i++) drive(1, 0, 5, '0, 1, 0, 3, '0);
        @(negedge clk); reset = 1'b1;
        at_edge();
        chk("rst_valid_a_u0", dva0, 0);
        chk("rst_valid_b_u0", dvb0, 0);
        chk("rst_valid_a_u1", dva1, 0);
        chk("rst_dout_a_u1", dout_a1, 0);
        chk("rst_init_done", idn0, 0);
        @(negedge clk);
        reset = 1'b0;
        en_a = 1; we_a = 1; addr_a = 4'd5; din_a = 16'h5555;
        en_b = 1; we_b = 1; addr_b = 4'd3; din_b = 16'h3333;
        repeat (15) @(negedge clk);
        chk("sweep_ignore_va", dva0, 0);
        chk("sweep_ignore_vb", dvb0, 0);
        drive(1, 0, 5, '0, 1, 0, 3, '0);
        at_edge();
        chk("post_rst_rd5", dout_a0, 16'h1234);
        chk("post_rst_rd3", dout_b0, 16'h1234);

        // random two-port traffic on a few addresses to provoke clashes
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), 16'($urandom));
        end
        idle();
        repeat (3) at_edge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
